// File: rtl/mem_write_buffer.sv
// Posted write buffer between the D-cache memory port and slow memory.
// Line write-backs are absorbed into a small FIFO and drained in the background.
// Reads are served from the buffer on a hit and forwarded to slow memory on a miss.
//
//  state | meaning
//  IDLE  | no memory transaction; choose read miss first, then drain
//  DRAIN | head entry being written to slow memory (m_write held)
//  READ  | read miss forwarded to slow memory (m_read held)
//  RESP  | miss data returned to the cache, c_ready high for one cycle
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 28,
    parameter int DW    = 128
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_c_read,
    input  logic          i_c_write,
    input  logic [AW-1:0] i_c_addr,
    input  logic [DW-1:0] i_c_wdata,
    output logic [DW-1:0] o_c_rdata,
    output logic          o_c_ready,
    output logic          o_m_read,
    output logic          o_m_write,
    output logic [AW-1:0] o_m_addr,
    output logic [DW-1:0] o_m_wdata,
    input  logic [DW-1:0] i_m_rdata,
    input  logic          i_m_ready,
    output logic          o_wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_READ, ST_RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_c_ready;
    logic [DW-1:0]    r_c_rdata;
    logic [AW-1:0]    r_miss_addr;

    logic [PW-1:0]    w_idx;
    logic             w_rd_hit;
    logic [PW-1:0]    w_rd_idx;
    logic             w_wr_hit;
    logic [PW-1:0]    w_wr_idx;
    logic             w_req_ok;
    logic             w_pop;
    logic             w_wr_coal;
    logic             w_wr_push;
    logic             w_rd_serve;
    logic             w_rd_miss;

    // Address match scan from oldest to youngest so the youngest match wins;
    // the head being drained is a read hit but never a coalesce target.
    always_comb begin
        w_idx    = '0;
        w_rd_hit = 1'b0;
        w_rd_idx = '0;
        w_wr_hit = 1'b0;
        w_wr_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_valid[w_idx] && (r_addr[w_idx] == i_c_addr)) begin
                w_rd_hit = 1'b1;
                w_rd_idx = w_idx;
                if (!((r_state == ST_DRAIN) && (w_idx == r_head))) begin
                    w_wr_hit = 1'b1;
                    w_wr_idx = w_idx;
                end
            end
        end
    end

    // Request qualification; a request seen while c_ready is high is the one being completed.
    // A pop in the same cycle frees the slot, so a write to a full buffer can be pushed then.
    always_comb begin
        w_req_ok   = !r_c_ready;
        w_pop      = (r_state == ST_DRAIN) && i_m_ready;
        w_wr_coal  = i_c_write && w_req_ok && w_wr_hit;
        w_wr_push  = i_c_write && w_req_ok && !w_wr_hit && ((r_count < FULL) || w_pop);
        w_rd_serve = i_c_read && w_req_ok && w_rd_hit &&
                     ((r_state == ST_IDLE) || (r_state == ST_DRAIN));
        w_rd_miss  = i_c_read && w_req_ok && !w_rd_hit;
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory-side outputs; read misses take priority over draining.
    always_comb begin
        w_state_nxt = r_state;
        o_m_read    = 1'b0;
        o_m_write   = 1'b0;
        o_m_addr    = '0;
        o_m_wdata   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_miss) begin
                    w_state_nxt = ST_READ;
                end else if (r_count != '0) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_m_write = 1'b1;
                o_m_addr  = r_addr[r_head];
                o_m_wdata = r_data[r_head];
                if (i_m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                o_m_read = 1'b1;
                o_m_addr = r_miss_addr;
                if (i_m_ready) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO storage: pop the drained head, coalesce or push incoming writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_addr[k] <= '0;
                r_data[k] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_wr_coal) begin
                r_data[w_wr_idx] <= i_c_wdata;
            end
            if (w_wr_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= i_c_addr;
                r_data[r_tail]  <= i_c_wdata;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_wr_push) - CW'(w_pop);
        end
    end

    // Cache response: one-cycle c_ready for accepted writes, read hits and returned misses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c_ready   <= 1'b0;
            r_c_rdata   <= '0;
            r_miss_addr <= '0;
        end else begin
            r_c_ready <= w_wr_coal || w_wr_push || w_rd_serve ||
                         ((r_state == ST_READ) && i_m_ready);
            if (w_rd_serve) begin
                r_c_rdata <= r_data[w_rd_idx];
            end else if ((r_state == ST_READ) && i_m_ready) begin
                r_c_rdata <= i_m_rdata;
            end
            if ((r_state == ST_IDLE) && w_rd_miss) begin
                r_miss_addr <= i_c_addr;
            end
        end
    end

    assign o_c_ready  = r_c_ready;
    assign o_c_rdata  = r_c_rdata;
    assign o_wb_empty = (r_count == '0) && (r_state != ST_DRAIN);

endmodule

// File: tb/tb_mem_write_buffer.sv
// Testbench for mem_write_buffer with a slow memory model.
module tb_mem_write_buffer;
    localparam int MEM_LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         c_read, c_write;
    logic [27:0]  c_addr;
    logic [127:0] c_wdata, c_rdata;
    logic         c_ready;
    logic         m_read, m_write;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata, m_rdata;
    logic         m_ready;
    logic         wb_empty;

    int errors = 0;
    int checks = 0;

    mem_write_buffer #(.DEPTH(4), .AW(28), .DW(128)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c_read(c_read), .i_c_write(c_write), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_rdata(c_rdata), .o_c_ready(c_ready),
        .o_m_read(m_read), .o_m_write(m_write), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
        .i_m_rdata(m_rdata), .i_m_ready(m_ready), .o_wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    // Background contents of never-written memory lines.
    function automatic logic [127:0] bg(input logic [27:0] a);
        return {4{4'h0, a}};
    endfunction

    // Slow memory model: fixed latency, can be stalled with mem_hold, cleared by reset.
    logic [127:0] mem [logic [27:0]];
    bit           mem_hold = 1'b0;
    int           lat_cnt;

    function automatic logic [127:0] mem_rd(input logic [27:0] a);
        return mem.exists(a) ? mem[a] : bg(a);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b0;
            m_rdata <= '0;
            lat_cnt <= 0;
            mem.delete();
        end else if (m_ready) begin
            m_ready <= 1'b0;
            lat_cnt <= 0;
        end else if ((m_read || m_write) && !mem_hold) begin
            if (lat_cnt == MEM_LAT) begin
                m_ready <= 1'b1;
                lat_cnt <= 0;
                if (m_write) mem[m_addr] = m_wdata;
                else         m_rdata <= mem_rd(m_addr);
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // Protocol monitor.
    bit overlap_seen = 1'b0;
    bit both_req_seen = 1'b0;
    int mwr_cyc = 0, mrd_cyc = 0, wr_txn = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_read && m_write) overlap_seen = 1'b1;
            if (c_read && c_write) both_req_seen = 1'b1;
            if (m_write) mwr_cyc++;
            if (m_read)  mrd_cyc++;
            if (m_ready && m_write) wr_txn++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cache request held until c_ready; lat = sampled cycles after the first accepting edge.
    task automatic cache_op(input bit wr, input logic [27:0] a, input logic [127:0] d,
                            output logic [127:0] rd, output bit ok, output int lat);
        @(posedge clk); #1;
        c_read = !wr; c_write = wr; c_addr = a; c_wdata = d;
        ok = 1'b0; rd = '0; lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (c_ready) begin
                ok = 1'b1; rd = c_rdata; lat = i;
                break;
            end
        end
        c_read = 1'b0; c_write = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (wb_empty) begin got = 1'b1; break; end
        end
        chk(name, got, 1);
    endtask

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;   // write data, or expected read data
    } vec_t;

    initial begin
        vec_t         tbl [11];
        logic [127:0] rd;
        bit           ok;
        int           lat, mrd0, wr0, mwr0, t_mr, t_cr;
        bit           bad;
        logic [127:0] ref_mem [logic [27:0]];

        tbl[0]  = '{1'b1, 28'h60, 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004};
        tbl[1]  = '{1'b1, 28'h61, 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004};
        tbl[2]  = '{1'b0, 28'h60, 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004};
        tbl[3]  = '{1'b1, 28'h60, 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004};
        tbl[4]  = '{1'b0, 28'h60, 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004};
        tbl[5]  = '{1'b0, 28'h62, 128'h0000_0062_0000_0062_0000_0062_0000_0062};
        tbl[6]  = '{1'b0, 28'h61, 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004};
        tbl[7]  = '{1'b1, 28'h63, 128'hDDDD_0001_DDDD_0002_DDDD_0003_DDDD_0004};
        tbl[8]  = '{1'b0, 28'h63, 128'hDDDD_0001_DDDD_0002_DDDD_0003_DDDD_0004};
        tbl[9]  = '{1'b0, 28'h70, 128'h0000_0070_0000_0070_0000_0070_0000_0070};
        tbl[10] = '{1'b0, 28'h60, 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004};

        rst = 1'b1; c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c_ready", c_ready, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_wb_empty", wb_empty, 1);
        rst = 1'b0;

        // 1: write then read hit while the entry is the in-flight head
        mem_hold = 1'b1;
        mrd0 = mrd_cyc;
        cache_op(1'b1, 28'h10, 128'hD0D0_0000_0000_0000_0000_0000_0000_00D0, rd, ok, lat);
        chk("t1_wr_lat", lat, 0);
        cache_op(1'b0, 28'h10, '0, rd, ok, lat);
        chk("t1_rd_lat", lat, 0);
        chk("t1_rd_data", rd, 128'hD0D0_0000_0000_0000_0000_0000_0000_00D0);
        chk("t1_no_mread", mrd_cyc - mrd0, 0);
        mem_hold = 1'b0;
        wait_empty("t1_empty");

        // 2: fifth write stalls on a full buffer; released by the first drain
        mem_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cache_op(1'b1, 28'h10 + 28'(k), {32'h2000_0000 + k, 96'h0}, rd, ok, lat);
            chk("t2_wr_ok", ok, 1);
        end
        @(posedge clk); #1;
        c_write = 1'b1; c_addr = 28'h14; c_wdata = {32'h2000_0004, 96'h0};
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (c_ready) bad = 1'b1;
        end
        chk("t2_stall", bad, 0);
        chk("t2_not_empty", wb_empty, 0);
        mem_hold = 1'b0;
        t_mr = -1; t_cr = -1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_ready && t_mr < 0) t_mr = i;
            if (c_ready) begin t_cr = i; break; end
        end
        c_write = 1'b0;
        chk("t2_mready_seen", t_mr >= 0, 1);
        chk("t2_cready_after_mready", t_cr, t_mr + 1);
        wait_empty("t2_empty");
        for (int k = 0; k < 5; k++)
            chk("t2_mem", mem_rd(28'h10 + 28'(k)), {32'h2000_0000 + k, 96'h0});

        // 3: coalesce two writes to 0x20 behind an in-flight head
        mem_hold = 1'b1;
        wr0 = wr_txn;
        cache_op(1'b1, 28'h10, 128'hE0, rd, ok, lat);
        cache_op(1'b1, 28'h20, 128'hD1, rd, ok, lat);
        cache_op(1'b1, 28'h20, 128'hD2, rd, ok, lat);
        chk("t3_wr_ok", ok, 1);
        mem_hold = 1'b0;
        wait_empty("t3_empty");
        chk("t3_wr_txns", wr_txn - wr0, 2);
        chk("t3_mem20", mem_rd(28'h20), 128'hD2);
        chk("t3_mem10", mem_rd(28'h10), 128'hE0);

        // 4: read miss during a drain waits for the drain to finish
        mem_hold = 1'b1;
        wr0 = wr_txn;
        mrd0 = mrd_cyc;
        cache_op(1'b1, 28'h10, 128'hF0, rd, ok, lat);
        @(posedge clk); #1;
        c_read = 1'b1; c_addr = 28'h30;
        bad = 1'b0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 4) mem_hold = 1'b0;
            @(posedge clk); #1;
            if (m_read && (wr_txn == wr0)) bad = 1'b1;
            if (c_ready) begin ok = 1'b1; rd = c_rdata; break; end
        end
        c_read = 1'b0;
        chk("t4_done", ok, 1);
        chk("t4_rdata", rd, 128'h0000_0030_0000_0030_0000_0030_0000_0030);
        chk("t4_order", bad, 0);
        chk("t4_mread_used", (mrd_cyc - mrd0) > 0, 1);
        chk("t4_one_drain", wr_txn - wr0, 1);
        wait_empty("t4_empty");

        // 5: reset in the middle of a drain
        mem_hold = 1'b1;
        cache_op(1'b1, 28'h40, 128'h4040, rd, ok, lat);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_draining", m_write, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_c_ready", c_ready, 0);
        chk("t5_c_rdata", c_rdata, 0);
        chk("t5_m_read", m_read, 0);
        chk("t5_m_write", m_write, 0);
        chk("t5_m_addr", m_addr, 0);
        chk("t5_m_wdata", m_wdata, 0);
        chk("t5_wb_empty", wb_empty, 1);
        mem_hold = 1'b0;
        mwr0 = mwr_cyc;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_mwrite", mwr_cyc - mwr0, 0);
        chk("t5_empty_after", wb_empty, 1);

        // Directed vector table
        for (int v = 0; v < 11; v++) begin
            cache_op(tbl[v].wr, tbl[v].addr, tbl[v].data, rd, ok, lat);
            chk($sformatf("vec%0d_ready", v), ok, 1);
            if (!tbl[v].wr) chk($sformatf("vec%0d_rdata", v), rd, tbl[v].data);
        end
        wait_empty("vec_empty");

        // 6: random reads/writes against a reference array
        for (int n = 0; n < 2000; n++) begin
            logic [27:0]  a;
            logic [127:0] d;
            bit           w;
            a = 28'h80 + 28'($urandom_range(0, 7));
            w = ($urandom_range(0, 1) == 1);
            d = {$urandom, $urandom, $urandom, $urandom};
            cache_op(w, a, d, rd, ok, lat);
            if (!ok) begin
                chk("rand_timeout", ok, 1);
            end else if (w) begin
                ref_mem[a] = d;
            end else begin
                chk($sformatf("rand%0d_rdata", n), rd, ref_mem.exists(a) ? ref_mem[a] : bg(a));
            end
        end
        wait_empty("rand_empty");
        for (int k = 0; k < 8; k++) begin
            logic [27:0] a;
            a = 28'h80 + 28'(k);
            chk("rand_mem", mem_rd(a), ref_mem.exists(a) ? ref_mem[a] : bg(a));
        end

        chk("no_mrd_mwr_overlap", overlap_seen, 0);
        chk("no_rd_wr_both", both_req_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
